// File: rtl/complete_arbiter.sv
// complete_arbiter
//   Shares the single register-file completion port among N_REQ execution
//   units. Round-robin selection with a registered output stage. A flash
//   (pipeline flush) drops the held output and rejects every request that
//   cycle.
//
// Handshake: req_en[i] is "valid" and ~req_reject[i] is "ready"; unit i's
// message transfers on a clock edge where req_en[i] & ~req_reject[i]. The
// output side works the same way: out_msg transfers where out_en & ~out_reject.
// A rejected requester holds req_en/req_msg stable until taken.
//
// Ports
//   clock       in   system clock, all state updates on posedge
//   reset       in   synchronous active-high reset
//   flash       in   pipeline flush
//   req_en      in   per-unit request valid
//   req_msg     in   per-unit message, unit i at [i*MSG_W +: MSG_W]
//   req_reject  out  combinational; 1 = message not taken this cycle
//   out_en      out  registered message valid
//   out_msg     out  registered granted message
//   out_src     out  registered index of the source unit
//   out_reject  in   downstream back-pressure, 1 = hold out_*

module complete_arbiter #(
    parameter int N_REQ = 4,
    parameter int MSG_W = 57,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flash,
    input  logic [N_REQ-1:0]       req_en,
    input  logic [N_REQ*MSG_W-1:0] req_msg,
    output logic [N_REQ-1:0]       req_reject,
    output logic                   out_en,
    output logic [MSG_W-1:0]       out_msg,
    output logic [ID_W-1:0]        out_src,
    input  logic                   out_reject
);

    logic [ID_W-1:0]  rr_ptr;
    logic             can_accept;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic [N_REQ-1:0] grant_onehot;
    logic [MSG_W-1:0] grant_msg;
    logic [ID_W:0]    scan;

    // The output register can take a new message when it is empty or its
    // current content is being consumed this cycle.
    assign can_accept = ~out_en | ~out_reject;

    // Round-robin scan starting at rr_ptr. The extra bit in 'scan' lets the
    // wrap be an explicit subtraction, so non-power-of-two N_REQ never
    // produces an out-of-range index.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(N_REQ)) begin
                scan = scan - (ID_W+1)'(N_REQ);
            end
            if (!grant_valid && req_en[scan[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan[ID_W-1:0];
            end
        end
        // Reset and flash both suppress the grant; so does a stalled output.
        if (reset || flash || !can_accept) begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin
        grant_msg = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_msg = req_msg[i*MSG_W +: MSG_W];
            end
        end
    end

    assign grant_onehot = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
    assign req_reject   = req_en & ~grant_onehot;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_en  <= 1'b0;
            out_msg <= '0;
            out_src <= '0;
            rr_ptr  <= '0;
        end else if (flash) begin
            // Held output is dropped even under back-pressure; msg/src keep
            // their stale value but are qualified by out_en=0.
            out_en <= 1'b0;
            rr_ptr <= '0;
        end else if (grant_valid) begin
            out_en  <= 1'b1;
            out_msg <= grant_msg;
            out_src <= grant_idx;
            rr_ptr  <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);
        end else if (can_accept) begin
            out_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complete_arbiter.sv
// tb_complete_arbiter
//   Randomized and directed stimulus against a queue-based reference model.
//   The model process pushes the expected {src,msg} when it predicts a grant;
//   a separate monitor pops and compares whenever the DUT hands a message to
//   the register file (out_en & ~out_reject). A second instance with N_REQ=3
//   covers the non-power-of-two wrap.

module tb_complete_arbiter;

    localparam int N  = 4;
    localparam int MW = 57;
    localparam int IW = 2;

    logic            clock;
    logic            reset;
    logic            flash;
    logic [N-1:0]    req_en;
    logic [N*MW-1:0] req_msg;
    logic [N-1:0]    req_reject;
    logic            out_en;
    logic [MW-1:0]   out_msg;
    logic [IW-1:0]   out_src;
    logic            out_reject;
    logic [MW-1:0]   msg_a [N];

    // N_REQ=3 instance
    logic            reset3;
    logic            flash3;
    logic [2:0]      req_en3;
    logic [3*MW-1:0] req_msg3;
    logic [2:0]      req_reject3;
    logic            out_en3;
    logic [MW-1:0]   out_msg3;
    logic [1:0]      out_src3;
    logic            out_reject3;

    int checks = 0;
    int errors = 0;

    logic [IW+MW-1:0] exp_q[$];

    // reference model state
    bit            chk_on = 0;
    logic          m_en   = 1'b0;
    logic [MW-1:0] m_msg  = '0;
    int            m_src  = 0;
    int            m_ptr  = 0;
    logic [N-1:0]  last_rej = '0;

    complete_arbiter #(.N_REQ(4), .MSG_W(MW)) dut (
        .clock(clock), .reset(reset), .flash(flash),
        .req_en(req_en), .req_msg(req_msg), .req_reject(req_reject),
        .out_en(out_en), .out_msg(out_msg), .out_src(out_src),
        .out_reject(out_reject)
    );

    complete_arbiter #(.N_REQ(3), .MSG_W(MW)) dut3 (
        .clock(clock), .reset(reset3), .flash(flash3),
        .req_en(req_en3), .req_msg(req_msg3), .req_reject(req_reject3),
        .out_en(out_en3), .out_msg(out_msg3), .out_src(out_src3),
        .out_reject(out_reject3)
    );

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_msg[i*MW +: MW] = msg_a[i];
    end

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] rand_msg();
        logic [MW-1:0] m;
        m[31:0]  = $urandom;
        m[47:32] = 16'($urandom);
        m[55:48] = 8'($urandom);
        m[56]    = 1'($urandom_range(0, 1));
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic rst, input logic fl, input logic [N-1:0] en, input logic orj);
        @(posedge clock);
        #1;
        reset      = rst;
        flash      = fl;
        req_en     = en;
        out_reject = orj;
    endtask

    task automatic cyc3(input logic rst, input logic [2:0] en, input logic orj);
        @(posedge clock);
        #1;
        reset3      = rst;
        req_en3     = en;
        out_reject3 = orj;
    endtask

    // ---------------- reference model ----------------
    // Grant = first requesting unit scanning from the pointer modulo N,
    // only when the output slot is free or draining and no flash/reset.
    always begin
        logic         can;
        bit           gv;
        int           g;
        logic [N-1:0] exp_rej;
        @(negedge clock);
        #1;
        if (chk_on) begin
            chk("out_en", out_en, m_en);
            chk("out_msg", out_msg, m_msg);
            chk("out_src", out_src, m_src);
        end
        can = !m_en || !out_reject;
        gv  = 0;
        g   = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!gv && req_en[i]) begin
                gv = 1;
                g  = i;
            end
        end
        if (reset) begin
            exp_rej = req_en;
            exp_q.delete();
            m_en  = 1'b0;
            m_msg = '0;
            m_src = 0;
            m_ptr = 0;
        end else begin
            if (!can || flash) gv = 0;
            exp_rej = req_en;
            if (gv) exp_rej[g] = 1'b0;
            if (flash) begin
                // an unconsumed held message is thrown away
                if (m_en && out_reject && exp_q.size() > 0) void'(exp_q.pop_front());
                m_en  = 1'b0;
                m_ptr = 0;
            end else if (gv) begin
                exp_q.push_back({IW'(g), msg_a[g]});
                m_en  = 1'b1;
                m_msg = msg_a[g];
                m_src = g;
                m_ptr = (g + 1) % N;
            end else if (can) begin
                m_en = 1'b0;
            end
        end
        if (chk_on) chk("req_reject", req_reject, exp_rej);
        last_rej = exp_rej;
        chk_on   = 1;
    end

    // ---------------- scoreboard monitor ----------------
    always begin
        logic [IW+MW-1:0] exp;
        @(negedge clock);
        if (out_en === 1'b1 && out_reject === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got src=%0d msg=%0h, expected no message", out_src, out_msg);
            end else begin
                exp = exp_q.pop_front();
                chk("scoreboard", {out_src, out_msg}, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] e;
        logic [N-1:0] en;
        logic         rst;
        logic         fl;
        logic         orj;

        reset = 1'b1; flash = 1'b0; req_en = 4'b1111; out_reject = 1'b0;
        for (int i = 0; i < N; i++) msg_a[i] = rand_msg();
        reset3 = 1'b1; flash3 = 1'b0; req_en3 = 3'b000; out_reject3 = 1'b0;
        req_msg3 = '0;

        // reset held two cycles with all units requesting
        cyc(1, 0, 4'b1111, 0);
        cyc(1, 0, 4'b1111, 0);
        @(negedge clock);
        chk("rst_out_en", out_en, 0);
        chk("rst_out_msg", out_msg, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_req_reject", req_reject, 4'b1111);

        // single request from unit 2
        cyc(0, 0, 4'b0100, 0);
        msg_a[2] = {1'b0, 8'h11, 16'h0022, 32'hDEADBEEF};
        @(negedge clock);
        chk("single_reject", req_reject, 4'b0000);
        cyc(0, 0, 4'b0000, 0);
        @(negedge clock);
        chk("single_out_en", out_en, 1);
        chk("single_out_src", out_src, 2);
        chk("single_data", out_msg[31:0], 32'hDEADBEEF);

        // flash to park the pointer at 0, then round-robin with all requesting
        cyc(0, 1, 4'b0000, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 4'b1111, 0);
            @(negedge clock);
            e = 4'b1111;
            e[k % 4] = 1'b0;
            chk("rr_reject", req_reject, e);
            if (k > 0) chk("rr_src", out_src, (k - 1) % 4);
        end
        cyc(0, 0, 4'b0000, 0);
        @(negedge clock);
        chk("rr_src_last", out_src, 3);

        // back-pressure: unit 1 held under out_reject, then release
        cyc(0, 0, 4'b0010, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 4'b1001, 1);
            @(negedge clock);
            chk("bp_out_en", out_en, 1);
            chk("bp_out_src", out_src, 1);
            chk("bp_reject", req_reject, 4'b1001);
        end
        cyc(0, 0, 4'b1001, 0);
        @(negedge clock);
        chk("bp_release_reject", req_reject, 4'b0001);
        cyc(0, 0, 4'b0001, 0);
        @(negedge clock);
        chk("bp_release_src", out_src, 3);

        // flash while the output is stalled
        cyc(0, 1, 4'b0011, 1);
        @(negedge clock);
        chk("flash_reject", req_reject, 4'b0011);
        cyc(0, 0, 4'b0011, 0);
        @(negedge clock);
        chk("flash_out_en", out_en, 0);
        chk("flash_next_reject", req_reject, 4'b0010);
        cyc(0, 0, 4'b0010, 0);
        @(negedge clock);
        chk("flash_next_src", out_src, 0);
        chk("flash_next_en", out_en, 1);

        // randomized traffic; rejected units keep their request stable
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            orj = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++) begin
                en[i] = last_rej[i] ? 1'b1 : ($urandom_range(0, 99) < 60);
            end
            cyc(rst, fl, en, orj);
            for (int i = 0; i < N; i++) begin
                if (!last_rej[i]) msg_a[i] = rand_msg();
            end
        end

        // drain
        for (int c = 0; c < 3; c++) cyc(0, 0, 4'b0000, 0);
        @(negedge clock);
        #2;
        chk("queue_empty", exp_q.size(), 0);

        // N_REQ=3: pointer at 2 must wrap to 0, never index 3
        req_msg3[0*MW +: MW] = {1'b1, 8'h01, 16'h0001, 32'hA0A0A0A0};
        req_msg3[1*MW +: MW] = {1'b0, 8'h02, 16'h0002, 32'hB1B1B1B1};
        req_msg3[2*MW +: MW] = {1'b0, 8'h03, 16'h0003, 32'hC2C2C2C2};
        cyc3(1, 3'b000, 0);
        cyc3(0, 3'b010, 0);
        cyc3(0, 3'b001, 0);
        @(negedge clock);
        chk("n3_wrap_reject", req_reject3, 3'b000);
        cyc3(0, 3'b000, 0);
        @(negedge clock);
        chk("n3_wrap_src", out_src3, 0);
        chk("n3_wrap_data", out_msg3, {1'b1, 8'h01, 16'h0001, 32'hA0A0A0A0});
        cyc3(0, 3'b111, 0);
        @(negedge clock);
        chk("n3_ptr1_reject", req_reject3, 3'b101);
        cyc3(0, 3'b000, 0);
        @(negedge clock);
        chk("n3_ptr1_src", out_src3, 1);
        for (int c = 0; c < 40; c++) begin
            cyc3(0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            @(negedge clock);
            chk("n3_src_range", (out_src3 <= 2'd2), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
